wb_regfile: RTL

Write-back stage plus architectural register file for the 5-stage pipeline. It is the consumer end of the MEM/WB pipeline register.
- Selects the write-back data (ALU result or memory load data) and commits it to a 32x32 register file.
- Serves the two ID-stage read ports, with same-cycle write-through bypass so that no WB->ID forwarding hazard exists.
- Keeps a retired-write counter for debug and performance visibility.

---
 rtl/wb_regfile_pkg.sv | 16 +
 rtl/wb_regfile_core.sv | 41 ++++
 rtl/wb_regfile.sv | 57 +++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants and encodings for the write-back stage and register file.
package wb_regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_N    = 2 ** ADDR_W;
  localparam int CNT_W    = 32;
  localparam int ZERO_REG = 0;
  localparam int NUM_RD   = 2;

  typedef enum logic {
    MEMTOREG_ALU = 1'b0,
    MEMTOREG_MEM = 1'b1
  } memtoreg_e;

endpackage

// File: rtl/wb_regfile_core.sv
// Architectural register file: one write port, NUM_RD write-first bypassed read ports.
module regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W,
  parameter int REG_N  = wb_regfile_pkg::REG_N,
  parameter int NUM_RD = wb_regfile_pkg::NUM_RD
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  output logic                           we,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [REG_N];

  // wr_en gates first so an X index or data cannot leak into state on a bubble
  assign we = wr_en && (wr_addr != ZERO_IDX);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_data[p] = (rd_addr[p] == ZERO_IDX)              ? '0 :
                        (we && (wr_addr == rd_addr[p]))       ? wr_data :
                                                                mem[rd_addr[p]];
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result/load select, register file commit and retired-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W,
  parameter int REG_N  = wb_regfile_pkg::REG_N,
  parameter int CNT_W  = wb_regfile_pkg::CNT_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              WB_MemtoReg,
  input  logic              WB_RegWr,
  input  logic [ADDR_W-1:0] WB_Rw,
  input  logic [DATA_W-1:0] WB_Result,
  input  logic [DATA_W-1:0] WB_MemOut,
  input  logic [ADDR_W-1:0] Ra,
  input  logic [ADDR_W-1:0] Rb,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic [DATA_W-1:0] WB_busW,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic                          we;
  logic [1:0][ADDR_W-1:0]        rd_addr;
  logic [1:0][DATA_W-1:0]        rd_data;

  assign WB_busW = (memtoreg_e'(WB_MemtoReg) == MEMTOREG_MEM) ? WB_MemOut : WB_Result;

  assign rd_addr = {Rb, Ra};
  assign busA    = rd_data[0];
  assign busB    = rd_data[1];

  regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_N  (REG_N),
    .NUM_RD (2)
  ) u_core (
    .CLK     (CLK),
    .reset   (reset),
    .wr_en   (WB_RegWr),
    .wr_addr (WB_Rw),
    .wr_data (WB_busW),
    .we      (we),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Counts commits only; writes aimed at register 0 are dropped and not counted
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)  retire_cnt <= '0;
    else if (we) retire_cnt <= retire_cnt + CNT_W'(1);
  end

endmodule
